// File: rtl/riscv_ex_arbiter_pkg.sv
// riscv_ex_arbiter_pkg: EX function codes, lock FSM states and width helper for the EX arbiter
package riscv_ex_arbiter_pkg;
   localparam int EX_FUNCT_W = 4;
   localparam logic [EX_FUNCT_W-1:0] EX_ADD  = 4'd0;
   localparam logic [EX_FUNCT_W-1:0] EX_SUB  = 4'd1;
   localparam logic [EX_FUNCT_W-1:0] EX_XOR  = 4'd2;
   localparam logic [EX_FUNCT_W-1:0] EX_OR   = 4'd3;
   localparam logic [EX_FUNCT_W-1:0] EX_AND  = 4'd4;
   localparam logic [EX_FUNCT_W-1:0] EX_SLL  = 4'd5;
   localparam logic [EX_FUNCT_W-1:0] EX_SRL  = 4'd6;
   localparam logic [EX_FUNCT_W-1:0] EX_SRA  = 4'd7;
   localparam logic [EX_FUNCT_W-1:0] EX_SLT  = 4'd8;
   localparam logic [EX_FUNCT_W-1:0] EX_SLTU = 4'd9;
   localparam int NUM_EX_FUNCTS = 10;
   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/riscv_ex_arbiter_tag_fifo.sv
// riscv_ex_tag_fifo: sync tag FIFO, pointers wrap at DEPTH, no push-through-pop bypass when full
module riscv_ex_tag_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          wr_en, rd_en;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];
   // pointers and occupancy
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   // storage; entries are only read after being written
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/riscv_ex_arbiter.sv
// riscv_ex_arbiter: round-robin share of one EX pipe with in-order result routing; optional RISCV_EX_ARB_STATS_EN adds per-requester issue counters
module riscv_ex_arbiter
   import riscv_ex_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TAG_W           = idx_w(NUM_REQ),
   parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_rdy,
   output logic [NUM_REQ-1:0]         req_ack,
   input  logic [NUM_REQ*32-1:0]      req_op1,
   input  logic [NUM_REQ*32-1:0]      req_op2,
   input  logic [NUM_REQ*EX_FUNCT_W-1:0] req_funct,
   output logic                       ex_rdy,
   input  logic                       ex_ack,
   output logic [31:0]                ex_op1,
   output logic [31:0]                ex_op2,
   output logic [EX_FUNCT_W-1:0]      ex_funct,
   input  logic                       wb_rdy,
   output logic                       wb_ack,
   input  logic [31:0]                wb_data,
   output logic [NUM_REQ-1:0]         rsp_rdy,
   input  logic [NUM_REQ-1:0]         rsp_ack,
   output logic [31:0]                rsp_data,
   output logic [OUT_W-1:0]           outstanding,
   output logic                       err_underflow
`ifdef RISCV_EX_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]      stat_issue_cnt
`endif
);
   lock_state_t      state, state_nxt;
   logic             lock, full, empty, issue, pop;
   logic [TAG_W-1:0] rr_ptr, lock_idx, rr_grant, cand, grant, head;
   // first ready requester scanning upward from rr_ptr
   always_comb begin
      rr_grant = rr_ptr;
      cand     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_rdy[cand]) rr_grant = cand;
      end
   end
   assign grant    = lock ? lock_idx : rr_grant;
   assign ex_rdy   = !rst && req_rdy[grant] && !full;
   assign issue    = ex_rdy && ex_ack;
   assign ex_op1   = req_op1[32*grant +: 32];
   assign ex_op2   = req_op2[32*grant +: 32];
   assign ex_funct = req_funct[EX_FUNCT_W*grant +: EX_FUNCT_W];
   assign wb_ack   = !empty && rsp_ack[head];
   assign pop      = wb_rdy && wb_ack;
   assign rsp_data = wb_data;
   // issue ack goes to the granted requester only
   always_comb begin
      req_ack        = '0;
      req_ack[grant] = !rst && ex_ack && !full;
   end
   // result valid goes to the requester that issued the oldest outstanding op
   always_comb begin
      rsp_rdy       = '0;
      rsp_rdy[head] = wb_rdy && !empty;
   end
   // lock state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= UNLOCKED;
      else     state <= state_nxt;
   // lock while an offer is stalled, release on its transfer
   always_comb
      state_nxt = (state == UNLOCKED) ? ((ex_rdy && !ex_ack) ? LOCKED : UNLOCKED)
                                      : (issue ? UNLOCKED : LOCKED);
   // lock output decode
   always_comb
      lock = (state == LOCKED);
   // round-robin pointer, locked grant and sticky underflow flag
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rr_ptr        <= '0;
         lock_idx      <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (issue) rr_ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
         if (!lock && ex_rdy && !ex_ack) lock_idx <= grant;
         if (wb_rdy && empty) err_underflow <= 1'b1;
      end
   riscv_ex_tag_fifo #(
      .W     (TAG_W),
      .DEPTH (MAX_OUTSTANDING),
      .CW    (OUT_W)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (issue),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (outstanding)
   );
`ifdef RISCV_EX_ARB_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      // saturating count of issues granted to requester g
      always_ff @(posedge clk or posedge rst)
         if (rst) stat_issue_cnt[16*g +: 16] <= '0;
         else if (issue && grant == TAG_W'(g) && stat_issue_cnt[16*g +: 16] != 16'hFFFF)
            stat_issue_cnt[16*g +: 16] <= stat_issue_cnt[16*g +: 16] + 1'b1;
   end
`endif
endmodule

// File: tb/tb_riscv_ex_arbiter.sv
// tb_riscv_ex_arbiter: directed and random stimulus against a queue-based model of the EX arbiter
module tb_riscv_ex_arbiter;
   import riscv_ex_arbiter_pkg::*;
   localparam int N = 2;
   localparam int D = 4;
   logic                  clk = 1'b0, rst = 1'b1;
   logic [N-1:0]          req_rdy = '0, req_ack, rsp_rdy, rsp_ack = '0;
   logic [N*32-1:0]       req_op1 = '0, req_op2 = '0;
   logic [N*EX_FUNCT_W-1:0] req_funct = '0;
   logic                  ex_rdy, ex_ack = 1'b0, wb_rdy = 1'b0, wb_ack, err_underflow;
   logic [31:0]           ex_op1, ex_op2, wb_data = '0, rsp_data;
   logic [EX_FUNCT_W-1:0] ex_funct;
   logic [2:0]            outstanding;
`ifdef RISCV_EX_ARB_STATS_EN
   logic [N*16-1:0]       stat_issue_cnt;
`endif
   int n_cmp = 0, n_bad = 0;

   riscv_ex_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(D)) dut (
      .clk(clk), .rst(rst), .req_rdy(req_rdy), .req_ack(req_ack), .req_op1(req_op1),
      .req_op2(req_op2), .req_funct(req_funct), .ex_rdy(ex_rdy), .ex_ack(ex_ack),
      .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_funct(ex_funct), .wb_rdy(wb_rdy),
      .wb_ack(wb_ack), .wb_data(wb_data), .rsp_rdy(rsp_rdy), .rsp_ack(rsp_ack),
      .rsp_data(rsp_data), .outstanding(outstanding), .err_underflow(err_underflow)
`ifdef RISCV_EX_ARB_STATS_EN
      , .stat_issue_cnt(stat_issue_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] alu(logic [3:0] f, logic [31:0] a, logic [31:0] b);
      case (f)
         EX_ADD:  return a + b;
         EX_SUB:  return a - b;
         EX_XOR:  return a ^ b;
         EX_OR:   return a | b;
         default: return a & b;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   int          rr = 0, lk = 0, lidx = 0;
   int          tq[$];
   logic [31:0] rq[N][$];
   bit          m_err = 0;
   bit          s_iss = 0, s_stall = 0, s_pop = 0, s_und = 0;
   int          s_g = 0, s_hd = 0;
   logic [31:0] s_res = '0;

   always @(negedge clk) begin : cmp
      int g, hd;
      bit fnd, full, er;
      logic [N-1:0] e_ack, e_rsp;
      if (rst) begin
         rr = 0; lk = 0; m_err = 0; tq.delete();
         for (int i = 0; i < N; i++) rq[i].delete();
      end
      full = (tq.size() == D);
      g = rr; fnd = 0;
      if (lk != 0) g = lidx;
      else for (int k = 0; k < N; k++)
         if (!fnd && req_rdy[(rr + k) % N]) begin g = (rr + k) % N; fnd = 1; end
      er    = !rst && req_rdy[g] && !full;
      e_ack = (!rst && ex_ack && !full) ? N'(1 << g) : '0;
      hd    = (tq.size() > 0) ? tq[0] : -1;
      e_rsp = (wb_rdy && hd >= 0) ? N'(1 << hd) : '0;
      chk("ex_rdy", ex_rdy, er);
      chk("req_ack", req_ack, e_ack);
      chk("rsp_rdy", rsp_rdy, e_rsp);
      chk("wb_ack", wb_ack, hd >= 0 && rsp_ack[hd]);
      chk("outstanding", outstanding, tq.size());
      chk("err_underflow", err_underflow, m_err);
      if (er) begin
         chk("ex_op1", ex_op1, req_op1[32*g +: 32]);
         chk("ex_op2", ex_op2, req_op2[32*g +: 32]);
         chk("ex_funct", ex_funct, req_funct[EX_FUNCT_W*g +: EX_FUNCT_W]);
      end
      if (e_rsp != '0) chk("rsp_data", rsp_data, wb_data);
      s_pop = hd >= 0 && wb_rdy && rsp_ack[hd];
      if (s_pop) chk("rsp_route", {rq[hd].size() > 0, rsp_data},
                     {1'b1, (rq[hd].size() > 0) ? rq[hd][0] : 32'h0});
      s_g = g; s_hd = hd;
      s_iss   = er && ex_ack;
      s_stall = er && !ex_ack;
      s_und   = !rst && wb_rdy && hd < 0;
      s_res   = alu(req_funct[EX_FUNCT_W*g +: EX_FUNCT_W], req_op1[32*g +: 32], req_op2[32*g +: 32]);
   end

   always @(posedge clk) begin
      if (rst) begin
         rr = 0; lk = 0; m_err = 0; tq.delete();
         for (int i = 0; i < N; i++) rq[i].delete();
      end else begin
         if (s_iss) begin
            tq.push_back(s_g); rq[s_g].push_back(s_res);
            rr = (s_g + 1) % N; lk = 0;
         end else if (s_stall && lk == 0) begin
            lk = 1; lidx = s_g;
         end
         if (s_pop) begin
            void'(tq.pop_front());
            if (rq[s_hd].size() > 0) void'(rq[s_hd].pop_front());
         end
         if (s_und) m_err = 1;
      end
   end

   // ---------------- stimulus: requesters + pipe ----------------
   logic [31:0] pq[$];
   bit          held[N];
   bit          wb_en = 0, spur = 0;

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic adv();
      bit iss, wbt;
      logic [31:0] r;
      iss = ex_rdy && ex_ack;
      wbt = wb_rdy && wb_ack;
      r   = alu(ex_funct, ex_op1, ex_op2);
      for (int i = 0; i < N; i++) held[i] = req_rdy[i] && !req_ack[i];
      @(posedge clk); #1;
      if (rst) pq.delete();
      else begin
         if (iss) pq.push_back(r);
         if (wbt && pq.size() > 0) void'(pq.pop_front());
      end
      if (spur) begin
         wb_rdy = 1'b1; wb_data = $urandom;
      end else if (!(wb_rdy && !wbt && pq.size() > 0)) begin
         wb_rdy  = wb_en && pq.size() > 0;
         wb_data = wb_rdy ? pq[0] : 32'h0;
      end
   endtask

   task automatic cyc();
      settle(); adv();
   endtask

   task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic [3:0] f);
      req_op1[32*i +: 32] = a;
      req_op2[32*i +: 32] = b;
      req_funct[EX_FUNCT_W*i +: EX_FUNCT_W] = f;
   endtask

   task automatic drain();
      req_rdy = '0; rsp_ack = '1; wb_en = 1;
      for (int k = 0; k < 16 && (outstanding != 0 || wb_rdy); k++) cyc();
      settle(); chk("drain_outstanding", outstanding, 0); adv();
   endtask

   initial begin
      int gr[8];
      int c0, alt;
      // reset state
      req_rdy = 2'b11; ex_ack = 1; rsp_ack = 2'b11;
      settle();
      chk("rst_ex_rdy", ex_rdy, 0); chk("rst_req_ack", req_ack, 0);
      chk("rst_outstanding", outstanding, 0); chk("rst_err", err_underflow, 0);
      chk("rst_wb_ack", wb_ack, 0); chk("rst_rsp_rdy", rsp_rdy, 0);
      adv();
      req_rdy = '0; rst = 0; wb_en = 1;
      // single requester ADD 5+7
      set_req(0, 32'h5, 32'h7, EX_ADD); req_rdy = 2'b01;
      settle();
      chk("t1_ex_rdy", ex_rdy, 1); chk("t1_ex_op1", ex_op1, 32'h5); chk("t1_req_ack", req_ack, 2'b01);
      adv(); req_rdy = '0;
      settle();
      chk("t1_rsp_rdy", rsp_rdy, 2'b01); chk("t1_rsp_data", rsp_data, 32'hC); chk("t1_outstanding", outstanding, 1);
      adv();
      settle(); chk("t1_done", outstanding, 0); chk("t1_rsp_idle", rsp_rdy, 0); adv();
      // fairness: both requesters always ready
      set_req(0, 100, 1, EX_ADD); set_req(1, 101, 2, EX_SUB); req_rdy = 2'b11;
      c0 = 0; alt = 0;
      for (int k = 0; k < 8; k++) begin
         settle();
         gr[k] = (ex_rdy && ex_ack) ? int'(ex_op1) - 100 : -1;
         if (gr[k] == 0) c0++;
         if (k > 0 && gr[k] != gr[k-1] && gr[k] >= 0) alt++;
         adv();
      end
      chk("fair_first", gr[0], 1); chk("fair_cnt0", c0, 4); chk("fair_alternations", alt, 7);
      drain();
      // lock: point rr at requester 0 first
      set_req(1, 32'h1, 32'h1, EX_ADD); req_rdy = 2'b10; ex_ack = 1; cyc();
      set_req(0, 32'hA0, 32'h3, EX_AND); set_req(1, 32'hB0, 32'h4, EX_OR);
      req_rdy = 2'b11; ex_ack = 0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("lock_op1", ex_op1, 32'hA0); chk("lock_funct", ex_funct, EX_AND); chk("lock_ack", req_ack, 0);
         adv();
      end
      ex_ack = 1;
      settle(); chk("lock_release", req_ack, 2'b01); adv();
      req_rdy = 2'b10;
      settle(); chk("lock_next_op1", ex_op1, 32'hB0); chk("lock_next_ack", req_ack, 2'b10); adv();
      drain();
      // backpressure
      set_req(0, 32'h11, 32'h22, EX_XOR); req_rdy = 2'b01; ex_ack = 1; rsp_ack = '0;
      for (int k = 0; k < 4; k++) cyc();
      settle(); chk("bp_full", outstanding, 4); chk("bp_ex_rdy", ex_rdy, 0); adv();
      rsp_ack = 2'b11;
      settle(); chk("bp_pop_ack", wb_ack, 1); chk("bp_no_bypass", ex_rdy, 0); adv();
      rsp_ack = '0;
      settle(); chk("bp_after_pop", outstanding, 3); chk("bp_resume", ex_rdy, 1); adv();
      drain();
      // routing order
      wb_en = 0;
      set_req(1, 32'hFF, 32'h0F, EX_XOR); req_rdy = 2'b10; cyc();
      set_req(0, 32'd10, 32'd3, EX_SUB); req_rdy = 2'b01; cyc();
      req_rdy = '0; wb_en = 1; cyc();
      settle(); chk("route1_rdy", rsp_rdy, 2'b10); chk("route1_data", rsp_data, 32'hF0); adv();
      settle(); chk("route0_rdy", rsp_rdy, 2'b01); chk("route0_data", rsp_data, 32'h7); adv();
      drain();
      // reset mid-flight, then spurious wb_rdy
      wb_en = 0; req_rdy = 2'b01; ex_ack = 1;
      for (int k = 0; k < 3; k++) cyc();
      req_rdy = '0;
      settle(); chk("mid_outstanding", outstanding, 3); adv();
      rst = 1; req_rdy = 2'b01;
      settle(); chk("mid_rst_out", outstanding, 0); chk("mid_rst_ex_rdy", ex_rdy, 0); chk("mid_rst_err", err_underflow, 0); adv();
      rst = 0; req_rdy = '0; spur = 1; cyc();
      settle(); chk("spur_wb_ack", wb_ack, 0); adv();
      spur = 0;
      settle(); chk("spur_err", err_underflow, 1); adv();
      rst = 1; cyc(); rst = 0;
      // random traffic
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++)
            if (!held[i]) begin
               req_rdy[i] = ($urandom % 10) < 6;
               set_req(i, $urandom, $urandom, 4'($urandom_range(0, 4)));
            end
         ex_ack  = ($urandom % 3) != 0;
         rsp_ack = N'($urandom);
         wb_en   = ($urandom % 4) != 0;
         cyc();
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/riscv_ex_arbiter.md
Name: riscv_ex_arbiter

Overview:
Shares one riscv_ex_pipe between NUM_REQ issuing requesters, for example the integer decode front-end and a debug/CSR sequencer.
- Issue side: round-robin grant onto the pipe's id_ex rdy/ack interface. The grant is locked for the duration of any stalled handshake.
- Response side: a tag FIFO records the requester of each issued op. Each in-order mem_wb result is routed back to its originating requester.
- The block sits between decode-side requesters and riscv_ex_pipe.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
MAX_OUTSTANDING, 4, tag FIFO depth: maximum ops issued to the pipe whose result has not yet been accepted.
TAG_W, $clog2(NUM_REQ) (min 1), requester index width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_rdy  in  NUM_REQ  per-requester op valid
req_ack  out  NUM_REQ  per-requester op accepted
req_op1  in  NUM_REQ*32  packed operand 1, requester i at [32*i+:32]
req_op2  in  NUM_REQ*32  packed operand 2
req_funct  in  NUM_REQ*EX_FUNCT_W  packed function codes
ex_rdy  out  1  to pipe id_ex_rdy
ex_ack  in  1  from pipe id_ex_ack
ex_op1  out  32  to pipe id_ex_op1
ex_op2  out  32  to pipe id_ex_op2
ex_funct  out  EX_FUNCT_W  to pipe id_ex_funct
wb_rdy  in  1  from pipe mem_wb_rdy
wb_ack  out  1  to pipe mem_wb_ack
wb_data  in  32  from pipe mem_wb_data
rsp_rdy  out  NUM_REQ  per-requester result valid
rsp_ack  in  NUM_REQ  per-requester result accepted
rsp_data  out  32  result data, broadcast to all requesters; qualified by rsp_rdy
outstanding  out  $clog2(MAX_OUTSTANDING+1)  tag FIFO occupancy
err_underflow  out  1  sticky: wb_rdy seen while tag FIFO empty

Behaviour:
- Handshake: a transfer occurs in any cycle where rdy && ack. A producer holds rdy and data stable until the transfer.
- Registers: rr_ptr, lock, lock_idx, tag FIFO, err_underflow.
- Reset (async, rst=1):
  - rr_ptr=0, lock=0, FIFO empty, outstanding=0, err_underflow=0.
  - Therefore ex_rdy=0, wb_ack=0, rsp_rdy=0 and req_ack=0 for as long as rst is high.
- Grant selection (combinational, zero-latency pass-through):
  - If lock=1, grant=lock_idx.
  - Otherwise grant = first i with req_rdy[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - No requester asserting rdy: ex_rdy=0.
- Issue side:
  - full = (outstanding==MAX_OUTSTANDING).
  - ex_rdy = req_rdy[grant] && !full.
  - ex_op1/ex_op2/ex_funct = the granted requester's fields.
  - req_ack[i] = (i==grant) && ex_ack && !full.
- Lock state machine:
  - UNLOCKED→LOCKED when ex_rdy && !ex_ack; lock_idx latches grant.
  - LOCKED→UNLOCKED on the issue transfer.
  - Prevents the grant switching mid-handshake.
- Issue transfer (ex_rdy && ex_ack):
  - push grant into the tag FIFO;
  - rr_ptr ← (grant+1) mod NUM_REQ.
- Full FIFO: issue is blocked even if a pop occurs in the same cycle (no bypass); issue resumes the following cycle.
- Response side:
  - head = FIFO head tag.
  - rsp_rdy[i] = wb_rdy && !empty && (head==i).
  - wb_ack = !empty && rsp_ack[head].
  - rsp_data = wb_data.
  - Transfer (wb_rdy && wb_ack) pops the FIFO.
- Simultaneous push and pop when not full: occupancy unchanged, both complete.
- Empty FIFO with wb_rdy=1:
  - wb_ack=0;
  - err_underflow set and held until rst.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: all in-flight tags are discarded. The surrounding pipe is reset by the same reset.

Optional Feature:
RISCV_EX_ARB_STATS_EN
- Defined:
  - adds output stat_issue_cnt (NUM_REQ*16), one 16-bit counter per requester;
  - counter i increments on each issue transfer granted to i and saturates at 16'hFFFF;
  - counters are cleared by rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header riscv_functions.vh holds EX_FUNCT_W, the EX_* function codes and a NUM_EX_FUNCTS constant. The arbiter passes funct through opaquely.
- One natural sub-module: riscv_ex_tag_fifo, a sync FIFO of width TAG_W and depth MAX_OUTSTANDING, with push/pop/full/empty/count outputs and no bypass.

Test Plan:
- Single requester: req_rdy=2'b01, pipe acks every cycle, EX_ADD 0x5+0x7 → ex_op1=0x5, rsp_rdy[0]=1, rsp_data=0x0000000C, rsp_rdy[1] never asserted.
- Fairness: both requesters hold rdy, ex_ack=1 continuously, 8 ops → grants alternate 0,1,0,1…, 4 per requester.
- Lock: req 0 granted, ex_ack=0 for 3 cycles while req 1 also asserts rdy → ex_op1/funct stay on req 0 all 3 cycles; req 1 issues next.
- Backpressure: rsp_ack=0 and pipe ack=1 → 4 issues, then outstanding=4 and ex_rdy=0. Set rsp_ack=1 → one pop, then issue resumes the next cycle.
- Routing order: issue req1 EX_XOR 0xFF^0x0F, then req0 EX_SUB 10-3 → rsp_rdy[1] with 0x000000F0 first, then rsp_rdy[0] with 0x00000007.
- Reset mid-flight: assert rst with outstanding=3 → outstanding=0, ex_rdy=0, err_underflow=0; a spurious wb_rdy afterwards sets err_underflow=1.
